instr_encoder: RTL and testbench
================================

# instr_encoder

Packs decoded instruction descriptors into 32-bit machine words in the processor's ISA encoding and streams them, with sequential addresses, toward instruction memory. It is the encoder counterpart of the pipeline's decode stage and serves as the testbench and boot-time program loader. Descriptors are accepted with a valid/ready handshake and buffered in a small FIFO. Words are emitted on a valid/ready write stream, and a load-session state machine tracks start, drain and done.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_W`, 8: word-address width.
- `BASE_ADDR`, 0: first word address of a session.
- `clk` in 1: clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle pulse; begins a new session.
- `in_valid` in 1: descriptor valid.
- `in_ready` out 1: descriptor accepted when high with `in_valid`.
- `in_op` in 4: operation select.
- `in_rs`, `in_rt`, `in_rd` in 5 each: register fields.
- `in_imm` in 16: immediate, branch offset or jump target.
- `in_last` in 1: final descriptor of the session.
- `out_valid` out 1: encoded word valid.
- `out_ready` in 1: memory-side accept.
- `out_instr` out 32: encoded word.
- `out_addr` out ADDR_W: word address of `out_instr`.
- `count` out ADDR_W+1: words emitted this session.
- `done` out 1: session complete (level).
- `err` out 1: sticky illegal-op flag; tied 0 unless `ENC_CHECK_EN`.

## Operation
- Encoding of `in_op`:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL: R-type `{6'b000000, rs, rt, rd, 5'b0, funct}`. The funct values are 100000, 100010, 100100, 100101 and 011000 respectively.
  - 5 BEQ: I-type `{6'b000100, rs, rt, imm}`.
  - 6 BNE: I-type `{6'b001000, rs, rt, imm}`.
  - 7 LW: I-type `{6'd35, rs, rt, imm}`.
  - 8 SW: I-type `{6'd43, rs, rt, imm}`.
  - 9 JMP: `{6'b000010, 10'b0, imm}`.
  - 10–15: illegal (see Configuration).
- Unused descriptor fields are ignored.
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN when a beat with `in_last` is accepted.
  - DRAIN → DONE when the FIFO is empty and no word is outstanding.
  - DONE → RUN on `start`.
- `start` in any state has the following effects:
  - flushes the FIFO;
  - sets `out_addr` = `BASE_ADDR` and `count` = 0;
  - clears `done` and `err`;
  - moves the FSM to RUN.
- `in_ready` = (state==RUN) && FIFO not full. It depends only on registered state and does not look ahead to a same-cycle pop.
- Descriptors arriving while the FSM is in IDLE, DRAIN or DONE are not accepted.
- `out_valid` = FIFO not empty, with `out_instr` taken from the FIFO head.
- On each out handshake:
  - `out_addr` increments, wrapping modulo 2^ADDR_W;
  - `count` increments, saturating at 2^ADDR_W.
- `done` is high only in the DONE state.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_instr`=0;
  - `out_addr`=`BASE_ADDR`, `count`=0;
  - `done`=0, `err`=0;
  - FSM in IDLE, FIFO empty.
- Latency: with the FIFO empty, a descriptor accepted in cycle N gives `out_valid` high in cycle N+1.
- Throughput: one word per cycle while `out_ready` is held high.
- When the FIFO is full, `in_ready` drops the next cycle, even if a pop occurs in that same cycle.
- Push and pop in the same cycle leave the occupancy unchanged.
- `out_instr` and `out_addr` hold stable while `out_valid` is high and `out_ready` is low.
- `done` rises the cycle after the last word's handshake.
  - If `in_last` accompanies a dropped illegal beat and the FIFO is already empty, `done` rises the cycle after that accept.
- `start` coinciding with a handshake: `start` wins, and the beat is discarded.
- Deasserting `rst_n` mid-session returns everything to the reset values immediately (asynchronous).

## Configuration
- `ENC_CHECK_EN` defined:
  - An illegal op (10–15) is accepted (handshake completes) but produces no FIFO entry.
  - `err` is set and stays set until `start` or reset.
  - `in_last` on that beat still ends the session.
- `ENC_CHECK_EN` undefined:
  - An illegal op is encoded as 32'h00000000 (NOP) and emitted normally.
  - `err` is constant 0.

## Test plan
- Reset, `start`, ADD rs=1 rt=2 rd=3 (`in_last`=1), `out_ready`=1 → `out_instr`=0x00221820 at `out_addr` 0. `done` high 2 cycles after the accept. `count`=1.
- LW rs=4 rt=5 imm=0x0010, then SW rs=0 rt=7 imm=4, then BNE rs=1 rt=2 imm=0xFFFE → words 0x8C850010, 0xAC070004, 0x2022FFFE at addresses 0, 1, 2.
- `out_ready`=0 with 6 back-to-back MUL rs=1 rt=2 rd=3 (DEPTH=4) → `in_ready` low after 4 accepts. Release `out_ready` → 6 words of 0x00221818, in order and without loss.
- JMP imm=0x0040, then op 12 with `in_last` → with `ENC_CHECK_EN`: one word 0x08000040, `err`=1, `done`=1. Without it: 0x08000040 then 0x00000000, `err`=0.
- ADDR_W=2, 5 words emitted → addresses 0, 1, 2, 3, 0. `count`=4 (saturated).
- `start` pulse with 3 words pending → FIFO empty the next cycle, `out_addr`=0, `count`=0, `done`=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs instruction descriptors into 32-bit ISA words, buffers them in a FIFO and streams them
// with sequential addresses under a load-session FSM. Optional macro ENC_CHECK_EN drops illegal ops and sets err.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);
  localparam int                PW       = $clog2(DEPTH);
  localparam logic [PW:0]       FULL_OCC = (PW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state, state_nxt;
  desc_t         desc;
  logic [31:0]   enc;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ, occ_nxt;
  logic          full, empty, acc, push, pop;

  assign desc = {in_op, in_rs, in_rt, in_rd, in_imm};

  always_comb begin
    enc = 32'h0;
    case (desc.op)
      4'd0:    enc = {6'b000000, desc.rs, desc.rt, desc.rd, 5'b0, 6'b100000};
      4'd1:    enc = {6'b000000, desc.rs, desc.rt, desc.rd, 5'b0, 6'b100010};
      4'd2:    enc = {6'b000000, desc.rs, desc.rt, desc.rd, 5'b0, 6'b100100};
      4'd3:    enc = {6'b000000, desc.rs, desc.rt, desc.rd, 5'b0, 6'b100101};
      4'd4:    enc = {6'b000000, desc.rs, desc.rt, desc.rd, 5'b0, 6'b011000};
      4'd5:    enc = {6'b000100, desc.rs, desc.rt, desc.imm};
      4'd6:    enc = {6'b001000, desc.rs, desc.rt, desc.imm};
      4'd7:    enc = {6'd35, desc.rs, desc.rt, desc.imm};
      4'd8:    enc = {6'd43, desc.rs, desc.rt, desc.imm};
      4'd9:    enc = {6'b000010, 10'b0, desc.imm};
      default: enc = 32'h0;
    endcase
  end

  assign full      = (occ == FULL_OCC);
  assign empty     = (occ == '0);
  assign in_ready  = (state == S_RUN) && !full;
  assign out_valid = !empty;
  assign out_instr = empty ? 32'h0 : mem[rd_ptr];
  assign done      = (state == S_DONE);

  // start overrides any same-cycle handshake on either side
  assign acc = in_valid && in_ready && !start;
  assign pop = out_valid && out_ready && !start;

`ifdef ENC_CHECK_EN
  logic illegal, err_q;
  assign illegal = (in_op > 4'd9);
  assign push    = acc && !illegal;
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (start)            err_q <= 1'b0;
    else if (acc && illegal)   err_q <= 1'b1;
  end
`else
  assign push = acc;
  assign err  = 1'b0;
`endif

  assign occ_nxt = occ + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      out_addr <= BASE;
      count    <= '0;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      out_addr <= BASE;
      count    <= '0;
    end else begin
      occ <= occ_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        out_addr <= out_addr + ADDR_W'(1);
        if (count != CNT_MAX) count <= count + (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A dropped last beat with nothing left to drain finishes the session directly
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (acc && in_last) state_nxt = (occ_nxt == '0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (occ_nxt == '0) state_nxt = S_DONE;
      default: ;
    endcase
    if (start) state_nxt = S_RUN;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4, ADDR_W=2) with a queue-based reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef ENC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0] in_op = '0;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic in_ready, out_valid, done, err;
  logic [31:0] out_instr;
  logic [AW-1:0] out_addr;
  logic [AW:0] count;

  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_i[$], obs_i[$];
  int obs_a[$];
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .count(count), .done(done), .err(err));

  // Reference encoding from the ISA tables
  function automatic logic [31:0] ref_enc(input int unsigned op, rs, rt, rd, imm);
    int unsigned rf[5];
    int unsigned io[4];
    rf = '{32, 34, 36, 37, 24};
    io = '{4, 8, 35, 43};
    if (op < 5) return 32'((rs << 21) | (rt << 16) | (rd << 11) | rf[op]);
    if (op < 9) return 32'((io[op-5] << 26) | (rs << 21) | (rt << 16) | imm);
    if (op == 9) return 32'((2 << 26) | imm);
    return 32'h0;
  endfunction

  // Record handshakes of the current cycle into the model, then advance one clock
  task automatic step();
    bit acc, pop;
    acc = in_valid && in_ready && !start;
    pop = out_valid && out_ready && !start;
    if (pop) begin
      obs_i.push_back(out_instr);
      obs_a.push_back(int'(out_addr));
    end
    if (acc) begin
      if (CHK && in_op > 9) m_err = 1'b1;
      else exp_i.push_back(ref_enc(in_op, in_rs, in_rt, in_rd, in_imm));
    end
    if (start) begin
      exp_i.delete(); obs_i.delete(); obs_a.delete(); m_err = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send(input int op, rs, rt, rd, imm, input bit last, output bit ok);
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 16'(imm);
    in_last = last; in_valid = 1'b1; ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (in_ready) begin ok = 1'b1; step(); break; end
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #12;
    n_checks++; if ({in_ready, out_valid, done, err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {in_ready, out_valid, done, err}); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    n_checks++; if (out_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", out_addr); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got=%b exp=0", in_ready); end
    step(); in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_accept got=%b exp=0", out_valid); end
  endtask

  task automatic test_add();
    do_start();
    in_op = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got=%b exp=1", in_ready); end
    step(); in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00221820) begin n_fail++; $display("FAIL add_word got=%b/%h exp=1/00221820", out_valid, out_instr); end
    n_checks++; if (out_addr !== '0 || done !== 1'b0) begin n_fail++; $display("FAIL add_addr_done got=%0d/%b exp=0/0", out_addr, done); end
    step();
    n_checks++; if (done !== 1'b1 || count !== 3'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL add_done got=%b/%0d/%b exp=1/1/0", done, count, out_valid); end
  endtask

  task automatic test_itypes();
    bit ok1, ok2, ok3, okd;
    logic [31:0] want[3];
    want = '{32'h8C850010, 32'hAC070004, 32'h2022FFFE};
    do_start(); out_ready = 1'b1;
    send(7, 4, 5, 0, 16'h0010, 1'b0, ok1);
    send(8, 0, 7, 0, 16'h0004, 1'b0, ok2);
    send(6, 1, 2, 0, 16'hFFFE, 1'b1, ok3);
    wait_done(okd);
    n_checks++; if (!(ok1 && ok2 && ok3 && okd)) begin n_fail++; $display("FAIL itype_timeout got=%b%b%b%b exp=1111", ok1, ok2, ok3, okd); end
    n_checks++; if (obs_i.size() != 3) begin n_fail++; $display("FAIL itype_len got=%0d exp=3", obs_i.size()); end
    for (int i = 0; i < 3 && i < obs_i.size(); i++) begin
      n_checks++; if (obs_i[i] !== want[i] || obs_a[i] != i) begin n_fail++; $display("FAIL itype_word%0d got=%h@%0d exp=%h@%0d", i, obs_i[i], obs_a[i], want[i], i); end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    bit okd;
    do_start(); out_ready = 1'b0;
    in_op = 4'd4; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 8 && acc < 4; c++) begin
      if (in_ready) acc++;
      step();
    end
    n_checks++; if (acc != 4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got=%0d/%b exp=4/0", acc, in_ready); end
    step(); step();
    n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00221818 || out_addr !== '0) begin n_fail++; $display("FAIL bp_hold got=%b/%h/%0d exp=1/00221818/0", out_valid, out_instr, out_addr); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      in_last = (acc == 5);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(okd);
    n_checks++; if (acc != 6 || !okd || obs_i.size() != 6) begin n_fail++; $display("FAIL bp_drain got=%0d/%b/%0d exp=6/1/6", acc, okd, obs_i.size()); end
    for (int i = 0; i < obs_i.size(); i++) begin
      n_checks++; if (obs_i[i] !== 32'h00221818 || obs_a[i] != i % 4) begin n_fail++; $display("FAIL bp_word%0d got=%h@%0d exp=00221818@%0d", i, obs_i[i], obs_a[i], i % 4); end
    end
    n_checks++; if (count !== 3'd4 || out_addr !== 2'd2) begin n_fail++; $display("FAIL bp_sat got=%0d/%0d exp=4/2", count, out_addr); end
  endtask

  task automatic test_illegal();
    bit ok1, ok2, okd;
    do_start(); out_ready = 1'b1;
    send(9, 0, 0, 0, 16'h0040, 1'b0, ok1);
    send(12, 3, 4, 5, 16'h1234, 1'b1, ok2);
    wait_done(okd);
    n_checks++; if (!(ok1 && ok2 && okd)) begin n_fail++; $display("FAIL ill_timeout got=%b%b%b exp=111", ok1, ok2, okd); end
    n_checks++; if (obs_i.size() != (CHK ? 1 : 2)) begin n_fail++; $display("FAIL ill_len got=%0d exp=%0d", obs_i.size(), CHK ? 1 : 2); end
    if (obs_i.size() > 0) begin
      n_checks++; if (obs_i[0] !== 32'h08000040) begin n_fail++; $display("FAIL ill_jmp got=%h exp=08000040", obs_i[0]); end
    end
    if (!CHK && obs_i.size() > 1) begin
      n_checks++; if (obs_i[1] !== 32'h0) begin n_fail++; $display("FAIL ill_nop got=%h exp=0", obs_i[1]); end
    end
    n_checks++; if (err !== CHK || done !== 1'b1) begin n_fail++; $display("FAIL ill_err got=%b/%b exp=%b/1", err, done, CHK); end
    do_start();
    send(13, 0, 0, 0, 0, 1'b1, ok1);
    n_checks++; if (!ok1 || done !== CHK) begin n_fail++; $display("FAIL ill_last_done got=%b/%b exp=1/%b", ok1, done, CHK); end
    step();
    n_checks++; if (done !== 1'b1 || err !== CHK) begin n_fail++; $display("FAIL ill_last_done2 got=%b/%b exp=1/%b", done, err, CHK); end
  endtask

  task automatic test_start_flush();
    bit ok1, ok2, ok3, ok4;
    do_start(); out_ready = 1'b1;
    send(0, 1, 1, 1, 0, 1'b0, ok1);
    step(); out_ready = 1'b0;
    send(11, 0, 0, 0, 0, 1'b0, ok2);
    send(1, 2, 3, 4, 0, 1'b0, ok3);
    send(2, 5, 6, 7, 0, 1'b0, ok4);
    n_checks++; if (!(ok1 && ok2 && ok3 && ok4) || count !== 3'd1 || out_addr !== 2'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got=%b/%0d/%0d/%b exp=1/1/1/1", ok1 && ok2 && ok3 && ok4, count, out_addr, out_valid); end
    start = 1'b1; in_valid = 1'b1; in_op = 4'd0; out_ready = 1'b1;
    step(); start = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_addr !== '0 || count !== '0) begin n_fail++; $display("FAIL flush_state got=%b/%0d/%0d exp=0/0/0", out_valid, out_addr, count); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_flags got=%b/%b/%b exp=0/0/1", done, err, in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_beat_dropped got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    bit ok1, ok2, ok3;
    do_start(); out_ready = 1'b0;
    send(3, 1, 2, 3, 0, 1'b0, ok1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    send(1, 1, 2, 3, 0, 1'b0, ok2);
    send(2, 1, 2, 3, 0, 1'b0, ok3);
    n_checks++; if (!(ok1 && ok2 && ok3) || count !== 3'd1) begin n_fail++; $display("FAIL areset_pre got=%b/%0d exp=1/1", ok1 && ok2 && ok3, count); end
    #3 rst_n = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_instr !== 32'h0) begin n_fail++; $display("FAIL areset_hs got=%b/%b/%h exp=0/0/0", out_valid, in_ready, out_instr); end
    n_checks++; if (count !== '0 || out_addr !== '0 || done !== 1'b0) begin n_fail++; $display("FAIL areset_cnt got=%0d/%0d/%b exp=0/0/0", count, out_addr, done); end
    exp_i.delete(); obs_i.delete(); obs_a.delete(); m_err = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      int n, idx, occ, ne;
      bit running;
      do_start();
      n = $urandom_range(1, 10); idx = 0; running = 1'b1;
      for (int c = 0; c < 300; c++) begin
        occ = exp_i.size() - obs_i.size();
        n_checks++; if (out_valid !== (occ != 0) || in_ready !== (running && occ < DEPTH)) begin n_fail++; $display("FAIL rnd_hs s%0d c%0d got=%b/%b exp=%b/%b", s, c, out_valid, in_ready, occ != 0, running && occ < DEPTH); end
        n_checks++; if (done !== (!running && occ == 0)) begin n_fail++; $display("FAIL rnd_done s%0d c%0d got=%b exp=%b", s, c, done, !running && occ == 0); end
        if (!running && occ == 0) break;
        in_op = 4'($urandom_range(0, 15)); in_rs = 5'($urandom); in_rt = 5'($urandom);
        in_rd = 5'($urandom); in_imm = 16'($urandom);
        in_last = (idx == n - 1);
        in_valid = (idx < n) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        if (in_valid && in_ready) begin idx++; if (in_last) running = 1'b0; end
        step();
      end
      in_valid = 1'b0; in_last = 1'b0;
      ne = exp_i.size();
      n_checks++; if (running || obs_i.size() != ne) begin n_fail++; $display("FAIL rnd_len s%0d got=%0d exp=%0d", s, obs_i.size(), ne); end
      for (int i = 0; i < ne && i < obs_i.size(); i++) begin
        n_checks++; if (obs_i[i] !== exp_i[i] || obs_a[i] != i % 4) begin n_fail++; $display("FAIL rnd_word s%0d i%0d got=%h@%0d exp=%h@%0d", s, i, obs_i[i], obs_a[i], exp_i[i], i % 4); end
      end
      n_checks++; if (count !== 3'(ne > 4 ? 4 : ne) || out_addr !== 2'(ne % 4) || err !== m_err) begin n_fail++; $display("FAIL rnd_end s%0d got=%0d/%0d/%b exp=%0d/%0d/%b", s, count, out_addr, err, ne > 4 ? 4 : ne, ne % 4, m_err); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_itypes();
    test_backpressure();
    test_illegal();
    test_start_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
